regfile_mp: RTL

//  Parametrised multi-port register file for the pipelined datapath; next generation of the

---
 rtl/regfile_mp.sv | 125 ++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Purpose: multi-port register file with two write ports, write-through bypass,
//          optional hardwired zero register and per-register pending scoreboard.
// Latency: reads combinational (0 cycles); writes and scoreboard update on the rising clk_i edge.
// Backpressure: none; every write and reserve is accepted. Hazards are exposed via pa_busy_o/pend_o.
//
// Ports:
//   clk_i, rst_n_i            rising-edge clock, asynchronous active-low reset
//   ra_i / pa_o / pa_busy_o   NUM_RD packed read addresses, read data, per-port busy flag
//   we0_i rw0_i pw0_i         write port 0 (low priority)
//   we1_i rw1_i pw1_i         write port 1 (high priority, wins same-address collisions)
//   rsv_i rsv_addr_i          reserve: mark a register as having an outstanding producer
//   pend_o                    registered pending vector, one bit per register
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NUM_RD*ADDR_W-1:0]   ra_i,
    output logic [NUM_RD*DATA_W-1:0]   pa_o,
    output logic [NUM_RD-1:0]          pa_busy_o,
    input  logic                       we0_i,
    input  logic [ADDR_W-1:0]          rw0_i,
    input  logic [DATA_W-1:0]          pw0_i,
    input  logic                       we1_i,
    input  logic [ADDR_W-1:0]          rw1_i,
    input  logic [DATA_W-1:0]          pw1_i,
    input  logic                       rsv_i,
    input  logic [ADDR_W-1:0]          rsv_addr_i,
    output logic [(2**ADDR_W)-1:0]     pend_o
);

    localparam int DEPTH   = 2**ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);
    localparam bit BYP_EN  = (BYPASS != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;

    logic wr0_en;
    logic wr1_en;
    logic rsv_en;

    // Writes and reserves aimed at the hardwired zero register are dropped here,
    // so reg 0 can never hold data or become pending.
    assign wr0_en = we0_i && !(ZERO_EN && (rw0_i == '0));
    assign wr1_en = we1_i && !(ZERO_EN && (rw1_i == '0));
    assign rsv_en = rsv_i && !(ZERO_EN && (rsv_addr_i == '0));

    // Port 1 is applied after port 0 so it wins an address collision; the reserve
    // is applied after both clears so a new producer keeps the register pending.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr0_en) begin
            regs_d[rw0_i] = pw0_i;
            pend_d[rw0_i] = 1'b0;
        end
        if (wr1_en) begin
            regs_d[rw1_i] = pw1_i;
            pend_d[rw1_i] = 1'b0;
        end
        if (rsv_en) begin
            pend_d[rsv_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int n = 0; n < DEPTH; n++) begin
                regs_q[n] <= '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic              hit0;
        logic              hit1;
        logic [DATA_W-1:0] rd_dat;
        logic              rd_busy;

        assign rd_addr = ra_i[i*ADDR_W +: ADDR_W];

        always_comb begin
            hit0    = BYP_EN && we0_i && (rw0_i == rd_addr);
            hit1    = BYP_EN && we1_i && (rw1_i == rd_addr);
            rd_dat  = regs_q[rd_addr];
            rd_busy = pend_q[rd_addr];
            if (hit1) begin
                rd_dat = pw1_i;
            end else if (hit0) begin
                rd_dat = pw0_i;
            end
            // Forwarded data is the producer's result, so it is not a hazard.
            if (hit0 || hit1) begin
                rd_busy = 1'b0;
            end
            if (ZERO_EN && (rd_addr == '0)) begin
                rd_dat  = '0;
                rd_busy = 1'b0;
            end
            // Bypass would otherwise leak write data while the array is held in reset.
            if (!rst_n_i) begin
                rd_dat  = '0;
                rd_busy = 1'b0;
            end
        end

        assign pa_o[i*DATA_W +: DATA_W] = rd_dat;
        assign pa_busy_o[i]             = rd_busy;
    end

endmodule
